// File: rtl/led_pkg.sv
// Shared types and constants for the encoder readout: BCD digits, segment patterns, digit select.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package led_pkg;

  typedef logic [3:0] bcd_t;

  // Three BCD digits; packed so 12'h999 reads as the decimal value 999.
  typedef struct packed {
    bcd_t h;
    bcd_t t;
    bcd_t u;
  } bcd3_t;

  // Scan order of the multiplexed display.
  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } dig_sel_t;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam bcd3_t BCD3_ZERO = 12'h000;
  localparam bcd3_t BCD3_ONE  = 12'h001;
  localparam bcd3_t BCD3_MAX  = 12'h999;

  function automatic logic [6:0] seg_decode(input bcd_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // One-cold active-low digit enable for a given scan position.
  function automatic logic [2:0] dig_enable(input dig_sel_t s);
    logic [2:0] e;
    case (s)
      DIG_UNITS:    e = 3'b110;
      DIG_TENS:     e = 3'b101;
      DIG_HUNDREDS: e = 3'b011;
      default:      e = 3'b111;
    endcase
    return e;
  endfunction

  function automatic dig_sel_t dig_next(input dig_sel_t s);
    dig_sel_t n;
    case (s)
      DIG_UNITS: n = DIG_TENS;
      DIG_TENS:  n = DIG_HUNDREDS;
      default:   n = DIG_UNITS;
    endcase
    return n;
  endfunction

  // BCD +1 with 999 -> 000 wrap.
  function automatic bcd3_t bcd3_inc(input bcd3_t v);
    bcd3_t r;
    r = v;
    if (v.u == 4'd9) begin
      r.u = 4'd0;
      if (v.t == 4'd9) begin
        r.t = 4'd0;
        r.h = (v.h == 4'd9) ? 4'd0 : v.h + 4'd1;
      end else begin
        r.t = v.t + 4'd1;
      end
    end else begin
      r.u = v.u + 4'd1;
    end
    return r;
  endfunction

  // BCD -1 with 000 -> 999 wrap.
  function automatic bcd3_t bcd3_dec(input bcd3_t v);
    bcd3_t r;
    r = v;
    if (v.u == 4'd0) begin
      r.u = 4'd9;
      if (v.t == 4'd0) begin
        r.t = 4'd9;
        r.h = (v.h == 4'd0) ? 4'd9 : v.h - 4'd1;
      end else begin
        r.t = v.t - 4'd1;
      end
    end else begin
      r.u = v.u - 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/led_quad_decoder.sv
// Synchronises encoder phases A/B and decodes x4 quadrature steps, dropping double-phase changes.
// Latency: step_vld/fwd valid 2 clocks after a phase edge (combinational off the sync/prev registers).
// Backpressure: none; one step at most per clock, consumer must take it.
module quad_decoder (
  input  logic clk,
  input  logic rst_n,
  input  logic enc_a,
  input  logic enc_b,
  output logic step_vld,
  output logic fwd
);

  logic a_s1, a_s2, a_p;
  logic b_s1, b_s2, b_p;

  // Two-stage synchroniser followed by the previous-sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      a_p  <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
      b_p  <= 1'b0;
    end else begin
      a_s1 <= enc_a;
      a_s2 <= a_s1;
      a_p  <= a_s2;
      b_s1 <= enc_b;
      b_s2 <= b_s1;
      b_p  <= b_s2;
    end
  end

  // Exactly one phase changed is a step; both changing is illegal and yields nothing.
  assign step_vld = (a_s2 ^ a_p) ^ (b_s2 ^ b_p);
  // Forward order AB 00->10->11->01 always satisfies A ^ Bprev = 1.
  assign fwd      = a_s2 ^ b_p;

endmodule

// File: rtl/led_top.sv
// Quadrature encoder front end with BCD position/velocity counters and a 3-digit muxed 7-seg readout.
// Latency: position updates 3 clocks after a phase edge; display register 1 clock later within the scan.
// Backpressure: none; free-running, all outputs registered.
module led_top import led_pkg::*; #(
  parameter int CLK_HZ         = 12_000_000,
  parameter int GATE_CYCLES    = CLK_HZ / 10,
  parameter int REFRESH_CYCLES = CLK_HZ / 1000
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [5:0] Switch,
  input  logic       i_A,
  input  logic       i_B,
  output logic [7:0] SevenSegment,
  output logic [2:0] Enable
);

  localparam int GATE_W = $clog2(GATE_CYCLES * 8 + 1);
  localparam int SCAN_W = $clog2(REFRESH_CYCLES + 1);

  logic [3:0]        sw_s1, sw_s;
  logic [1:0]        mult_q;
  logic              step_vld, fwd;
  logic              dir_rev;
  bcd3_t             pos, vcnt, vel_reg, shown;
  logic [GATE_W-1:0] gate_cnt, gate_last;
  logic [SCAN_W-1:0] scan_cnt;
  dig_sel_t          sel;
  bcd_t              digit;
  logic              unused_sw;

  // Switch[5:4] are reserved and carry no function.
  assign unused_sw = ^Switch[5:4];

  quad_decoder u_dec (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .enc_a    (i_A),
    .enc_b    (i_B),
    .step_vld (step_vld),
    .fwd      (fwd)
  );

  // DIP switches are asynchronous to the board clock; synchronise before use.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      sw_s1 <= '0;
      sw_s  <= '0;
    end else begin
      sw_s1 <= Switch[3:0];
      sw_s  <= sw_s1;
    end
  end

  // Position up/down counter with level clear winning over steps; direction remembers the last step.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pos     <= BCD3_ZERO;
      dir_rev <= 1'b0;
    end else begin
      if (sw_s[1])       pos <= BCD3_ZERO;
      else if (step_vld) pos <= fwd ? bcd3_inc(pos) : bcd3_dec(pos);
      if (step_vld)      dir_rev <= ~fwd;
    end
  end

  assign gate_last = (GATE_W'(GATE_CYCLES) << sw_s[3:2]) - GATE_W'(1);

  // Gate timer and edge-rate counter; a step on a window boundary belongs to the new window.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mult_q   <= 2'd0;
      gate_cnt <= '0;
      vcnt     <= BCD3_ZERO;
      vel_reg  <= BCD3_ZERO;
    end else begin
      mult_q <= sw_s[3:2];
      if (sw_s[3:2] != mult_q) begin
        gate_cnt <= '0;
        vcnt     <= step_vld ? BCD3_ONE : BCD3_ZERO;
      end else if (gate_cnt == gate_last) begin
        gate_cnt <= '0;
        vel_reg  <= vcnt;
        vcnt     <= step_vld ? BCD3_ONE : BCD3_ZERO;
      end else begin
        gate_cnt <= gate_cnt + GATE_W'(1);
        if (step_vld && (vcnt != BCD3_MAX)) vcnt <= bcd3_inc(vcnt);
      end
    end
  end

  // Digit scan: hold each digit for REFRESH_CYCLES clocks, units -> tens -> hundreds.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      scan_cnt <= '0;
      sel      <= DIG_UNITS;
    end else if (scan_cnt == SCAN_W'(REFRESH_CYCLES - 1)) begin
      scan_cnt <= '0;
      sel      <= dig_next(sel);
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Pick the value chosen by Switch[0] and the digit currently being scanned.
  always_comb begin
    shown = sw_s[0] ? vel_reg : pos;
    digit = 4'hF;
    case (sel)
      DIG_UNITS:    digit = shown.u;
      DIG_TENS:     digit = shown.t;
      DIG_HUNDREDS: digit = shown.h;
      default:      digit = 4'hF;
    endcase
  end

  // Registered display drive; only the hundreds dp is used, lit while the last step was reverse.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      SevenSegment <= 8'hFF;
      Enable       <= 3'b111;
    end else begin
      SevenSegment <= {~((sel == DIG_HUNDREDS) && dir_rev), seg_decode(digit)};
      Enable       <= dig_enable(sel);
    end
  end

endmodule

// File: tb/tb_led_top.sv
// Directed bench for led_top: reset/scan checks, a table of position vectors, then velocity corner cases.
// Latency: n/a.
// Backpressure: n/a.
module tb_led_top;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [5:0] Switch;
  logic       i_A, i_B;
  logic [7:0] SevenSegment;
  logic [2:0] Enable;

  int applied    = 0;
  int miscompares = 0;
  int idx        = 0;

  typedef struct {
    logic       clr;
    int         n;
    logic [7:0] u;
    logic [7:0] t;
    logic [7:0] h;
  } vec_t;

  vec_t vecs[10];

  always #5 Clk = ~Clk;

  led_top #(
    .CLK_HZ         (12_000_000),
    .GATE_CYCLES    (1000),
    .REFRESH_CYCLES (10)
  ) dut (
    .Clk          (Clk),
    .Rst_n        (Rst_n),
    .Switch       (Switch),
    .i_A          (i_A),
    .i_B          (i_B),
    .SevenSegment (SevenSegment),
    .Enable       (Enable)
  );

  function automatic logic [1:0] pat(input int i);
    logic [1:0] p;
    case (i)
      0:       p = 2'b00;
      1:       p = 2'b10;
      2:       p = 2'b11;
      default: p = 2'b01;
    endcase
    return p;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  // Positive n = forward steps, negative = reverse; each phase level held 'hold' clocks.
  task automatic do_steps(input int n, input int hold);
    int cnt;
    cnt = (n < 0) ? -n : n;
    for (int k = 0; k < cnt; k++) begin
      idx = (n > 0) ? (idx + 1) % 4 : (idx + 3) % 4;
      {i_A, i_B} = pat(idx);
      repeat (hold) @(negedge Clk);
    end
  endtask

  task automatic read_disp(output logic [7:0] u, output logic [7:0] t, output logic [7:0] h,
                           output bit ok);
    bit gu, gt, gh;
    int cyc;
    gu = 0; gt = 0; gh = 0; cyc = 0;
    u = 8'hxx; t = 8'hxx; h = 8'hxx;
    while (!(gu && gt && gh) && cyc < 60) begin
      @(negedge Clk);
      cyc++;
      case (Enable)
        3'b110:  begin u = SevenSegment; gu = 1; end
        3'b101:  begin t = SevenSegment; gt = 1; end
        3'b011:  begin h = SevenSegment; gh = 1; end
        default: ;
      endcase
    end
    ok = gu && gt && gh;
  endtask

  task automatic check_disp(input string name, input logic [7:0] eu, input logic [7:0] et,
                            input logic [7:0] eh);
    logic [7:0] u, t, h;
    bit ok;
    read_disp(u, t, h, ok);
    if (!ok) begin
      applied++;
      miscompares++;
      $display("FAIL %s: digit scan never covered all three digits, last Enable=%b", name, Enable);
    end else begin
      chk({name, ".units"}, u, eu);
      chk({name, ".tens"}, t, et);
      chk({name, ".hundreds"}, h, eh);
    end
  endtask

  initial begin
    logic [7:0] ru, rt, rh;
    bit rok;

    vecs[0] = '{1'b0,    0, 8'hC0, 8'hC0, 8'hC0};  // idle: 000
    vecs[1] = '{1'b0,  100, 8'hC0, 8'hC0, 8'hF9};  // 100
    vecs[2] = '{1'b0, -101, 8'h90, 8'h90, 8'h10};  // 999, reverse dp lit
    vecs[3] = '{1'b0,    1, 8'hC0, 8'hC0, 8'hC0};  // wraps to 000, dp off
    vecs[4] = '{1'b0,   37, 8'hF8, 8'hB0, 8'hC0};  // 037
    vecs[5] = '{1'b0,  -40, 8'hF8, 8'h90, 8'h10};  // 997 reverse
    vecs[6] = '{1'b0,   12, 8'h90, 8'hC0, 8'hC0};  // 009 after wrap
    vecs[7] = '{1'b0,  258, 8'hF8, 8'h82, 8'hA4};  // 267
    vecs[8] = '{1'b1,   10, 8'hC0, 8'hC0, 8'hC0};  // cleared during burst
    vecs[9] = '{1'b0,    5, 8'h92, 8'hC0, 8'hC0};  // resumes from 000 -> 005

    Switch = 6'b0;
    i_A    = 1'b0;
    i_B    = 1'b0;
    Rst_n  = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_seg", SevenSegment, 8'hFF);
    chk("rst_en", {5'b0, Enable}, 8'h07);

    Rst_n = 1'b1;
    @(negedge Clk);
    chk("scan0_en", {5'b0, Enable}, 8'h06);
    chk("scan0_seg", SevenSegment, 8'hC0);
    repeat (10) @(negedge Clk);
    chk("scan1_en", {5'b0, Enable}, 8'h05);
    chk("scan1_seg", SevenSegment, 8'hC0);
    repeat (10) @(negedge Clk);
    chk("scan2_en", {5'b0, Enable}, 8'h03);
    chk("scan2_seg", SevenSegment, 8'hC0);
    repeat (10) @(negedge Clk);
    chk("scan3_en", {5'b0, Enable}, 8'h06);

    for (int v = 0; v < 10; v++) begin
      Switch[1] = vecs[v].clr;
      repeat (4) @(negedge Clk);
      do_steps(vecs[v].n, 3);
      repeat (6) @(negedge Clk);
      check_disp($sformatf("vec%0d", v), vecs[v].u, vecs[v].t, vecs[v].h);
    end

    // Both phases flip in the same sample (11 -> 00): position must stay 005.
    {i_A, i_B} = 2'b00;
    idx = 0;
    repeat (10) @(negedge Clk);
    check_disp("illegal_pos", 8'h92, 8'hC0, 8'hC0);

    // Only illegal transitions for over two gate windows: velocity must latch 000.
    Switch = 6'b000001;
    for (int k = 0; k < 80; k++) begin
      idx = idx ^ 2;
      {i_A, i_B} = pat(idx);
      repeat (30) @(negedge Clk);
    end
    check_disp("illegal_vel", 8'hC0, 8'hC0, 8'hC0);

    // Clear position, then toggle A alone: 50 clocks high, 5 low.
    Switch = 6'b000011;
    repeat (5) @(negedge Clk);
    Switch = 6'b000001;
    repeat (5) @(negedge Clk);
    fork
      begin
        for (int p = 0; p < 60; p++) begin
          i_A = 1'b1;
          repeat (50) @(negedge Clk);
          i_A = 1'b0;
          repeat (5) @(negedge Clk);
        end
      end
      begin
        repeat (2500) @(negedge Clk);
        read_disp(ru, rt, rh, rok);
        if (!rok) begin
          applied++;
          miscompares++;
          $display("FAIL toggle_vel: digit scan never covered all three digits");
        end else begin
          // 18 periods of 55 clocks give 36 steps; the 10 leftover clocks of a
          // 1000-clock window can hold 0..2 more edges depending on phase.
          applied++;
          if (!(ru == 8'h82 || ru == 8'hF8 || ru == 8'h80)) begin
            miscompares++;
            $display("FAIL toggle_vel.units: got %02h, expected 82/F8/80 (6..8)", ru);
          end
          chk("toggle_vel.tens", rt, 8'hB0);
          chk("toggle_vel.hundreds", {1'b0, rh[6:0]}, 8'h40);
        end
      end
    join
    // Last edge was a fall (reverse): position back to 000 with dp lit.
    Switch = 6'b000000;
    repeat (6) @(negedge Clk);
    check_disp("toggle_pos", 8'hC0, 8'hC0, 8'h40);

    // Longest gate (8000 clocks) restarted, then 1500 fast steps: saturates at 999.
    Switch = 6'b001101;
    repeat (4) @(negedge Clk);
    do_steps(1500, 2);
    repeat (5100) @(negedge Clk);
    check_disp("vel_sat", 8'h90, 8'h90, 8'h90);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/led_top.md
# led_top

Quadrature-encoder front end with a 3-digit multiplexed seven-segment readout, the top-level block of the board design. It synchronises two encoder phases and decodes them at x4 resolution. It keeps a BCD position counter and a BCD edge-rate (velocity) counter, and drives one of the two values onto the active-low seven-segment display, selected by the DIP switches.

## Interface
- CLK_HZ, 12_000_000: board clock frequency (informational; derives defaults).
- GATE_CYCLES, 1_200_000: base velocity gate window in clocks (100 ms).
- REFRESH_CYCLES, 12_000: clocks each digit stays enabled (1 ms).
- Clock and reset: one clock; reset is asynchronous and active-low.
- Clk  in  1  system clock; all logic is on the rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Switch  in  6  DIP switches, active-high.
  - [0]: 0 shows position, 1 shows velocity.
  - [1]: position clear, level-sensitive.
  - [3:2]: gate multiplier 1/2/4/8.
  - [5:4]: reserved, ignored.
- i_A  in  1  encoder phase A, asynchronous.
- i_B  in  1  encoder phase B, asynchronous.
- SevenSegment  out  8  active-low segments; [0]=a … [6]=g, [7]=dp.
- Enable  out  3  active-low digit enables, one-cold; [0]=units, [1]=tens, [2]=hundreds.

## Operation
- i_A, i_B and Switch each pass through a 2-FF synchroniser, then a previous-sample register (Ap, Bp).
- Step rule (A, B = current synchronised samples):
  - Exactly one of A or B changed: one step.
  - Forward when A ^ Bp = 1, otherwise reverse. Forward sequence AB: 00→10→11→01→00.
  - Both changed in the same sample: illegal, ignored, no count.
- Position: 3-digit BCD up/down counter.
  - Forward: +1, wrapping 999→000.
  - Reverse: −1, wrapping 000→999.
  - Switch[1]=1 holds it at 000; clear has priority over any step.
- Direction flag: set on a reverse step, cleared on a forward step. Drives the hundreds-digit dp (lit = reverse) in both modes.
- Velocity: a 3-digit BCD edge counter counts every legal step regardless of direction, saturating at 999.
  - Gate length = GATE_CYCLES << Switch[3:2].
  - At gate end the count is latched into the velocity display register and the counter restarts from 0.
  - A step in the gate-end cycle counts into the new window.
  - A change of Switch[3:2] restarts the current window without latching.
- Display: a scan counter advances the digit units→tens→hundreds→units every REFRESH_CYCLES. The selected 3-digit BCD value is decoded to segments (digits 0–9; codes 10–15 blank).
- Only the hundreds-digit dp may be lit; all other dps are off.

## Timing
- Reset values:
  - Position 000, velocity register 000, velocity counter 0, direction flag 0, gate and scan counters 0.
  - SevenSegment=8'hFF, Enable=3'b111.
- Outputs are registered. First clock after Rst_n deasserts: Enable=3'b110, units digit shown.
- Latency from an input edge to the position update: 3 clocks (2 synchroniser stages plus 1 decode).
- Latency to the displayed value: up to 1 further clock, plus the scan period before the digit is visible.
- Input phases must hold each level ≥2 clocks to be counted reliably.
- The velocity register updates exactly once per gate, on the final cycle of the window.
- Reset asserted mid-window discards the window; no partial latch.

## Structure
- Shared package holds:
  - Segment-pattern constants for 0–9 and blank.
  - The digit-select encoding.
  - The BCD digit type.
- Natural sub-module: `quad_decoder`, containing the synchronisers, step and direction outputs and the illegal-transition filter.
- The BCD counters, gate timer and display mux remain in `led_top`.
- Simulation uses GATE_CYCLES=1000 and REFRESH_CYCLES=10.

## Test plan
- Reset, then release with inputs idle:
  - Enable cycles 110→101→011 every 10 clocks.
  - Segments show "0" (8'hC0) on every digit.
  - All dps off.
- 25 forward quadrature cycles (100 steps) with Switch[0]=0 → display "100"; dp off.
- Then 101 reverse steps → display "999"; hundreds dp lit.
- i_A toggling alone (high 500 ns, low 50 ns at 10 ns clock), Switch[0]=1, gate 1000 clocks → velocity latches 36 steps per window. Position alternates between 000 and 001.
- Switch[1]=1 during a forward step burst → position stays 000; releasing it resumes counting from 000.
- A and B changed in the same clock → no count in either counter.
- Velocity saturation: 1500 steps in one window → velocity shows "999".
